// File: rtl/sram_2r_read_arbiter.sv
// Two-port graph SRAM read arbiter: round-robin grants up to two requesters per
// cycle, registers the SRAM addresses and routes the captured data back by tag.
module sram_2r_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 128
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0]         sram_addr1,
  output logic [ADDR_W-1:0]         sram_addr2,
  input  logic [DATA_W-1:0]         sram_data1,
  input  logic [DATA_W-1:0]         sram_data2
);
  localparam int PTR_W = $clog2(NUM_REQ);
  typedef logic [PTR_W-1:0] idx_t;

  idx_t              rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0] sram_addr1_q, sram_addr1_d;
  logic [ADDR_W-1:0] sram_addr2_q, sram_addr2_d;
  logic              p1_vld_q, p1_vld_d, p2_vld_q, p2_vld_d;
  idx_t              p1_tag_q, p1_tag_d, p2_tag_q, p2_tag_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q [NUM_REQ];
  logic [DATA_W-1:0] rsp_data_d [NUM_REQ];

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  idx_t              scan_idx [NUM_REQ];
  logic              g1_vld, g2_vld;
  idx_t              g1_idx, g2_idx, last_idx;
  logic [NUM_REQ-1:0] grant;

  // scan_idx[k] is the k-th requester visited when starting from rr_ptr
  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
    logic [PTR_W:0] sum;
    assign sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(gi);
    assign scan_idx[gi] = (sum >= (PTR_W+1)'(NUM_REQ)) ?
                          idx_t'(sum - (PTR_W+1)'(NUM_REQ)) : idx_t'(sum);
    assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    assign rsp_data[gi*DATA_W +: DATA_W] = rsp_data_q[gi];
  end

  always_comb begin
    g1_vld = 1'b0;
    g2_vld = 1'b0;
    g1_idx = '0;
    g2_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_valid[scan_idx[k]]) begin
        if (!g1_vld) begin
          g1_vld = 1'b1;
          g1_idx = scan_idx[k];
        end else if (!g2_vld) begin
          g2_vld = 1'b1;
          g2_idx = scan_idx[k];
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (g1_vld) grant[g1_idx] = 1'b1;
    if (g2_vld) grant[g2_idx] = 1'b1;
  end

  assign req_ready = reset ? '0 : grant;
  assign last_idx  = g2_vld ? g2_idx : g1_idx;

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    sram_addr1_d = sram_addr1_q;
    sram_addr2_d = sram_addr2_q;
    p1_tag_d     = p1_tag_q;
    p2_tag_d     = p2_tag_q;
    p1_vld_d     = g1_vld;
    p2_vld_d     = g2_vld;
    if (g1_vld) begin
      sram_addr1_d = addr_arr[g1_idx];
      p1_tag_d     = g1_idx;
      rr_ptr_d     = (last_idx == idx_t'(NUM_REQ-1)) ? '0 : last_idx + idx_t'(1);
    end
    if (g2_vld) begin
      sram_addr2_d = addr_arr[g2_idx];
      p2_tag_d     = g2_idx;
    end
  end

  // The two in-flight tags are always distinct, so both captures can land at once
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (p1_vld_q) begin
      rsp_valid_d[p1_tag_q] = 1'b1;
      rsp_data_d[p1_tag_q]  = sram_data1;
    end
    if (p2_vld_q) begin
      rsp_valid_d[p2_tag_q] = 1'b1;
      rsp_data_d[p2_tag_q]  = sram_data2;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      sram_addr1_q <= '0;
      sram_addr2_q <= '0;
      p1_vld_q     <= 1'b0;
      p2_vld_q     <= 1'b0;
      p1_tag_q     <= '0;
      p2_tag_q     <= '0;
      rsp_valid_q  <= '0;
      for (int i = 0; i < NUM_REQ; i++) rsp_data_q[i] <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      sram_addr1_q <= sram_addr1_d;
      sram_addr2_q <= sram_addr2_d;
      p1_vld_q     <= p1_vld_d;
      p2_vld_q     <= p2_vld_d;
      p1_tag_q     <= p1_tag_d;
      p2_tag_q     <= p2_tag_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign sram_addr1 = sram_addr1_q;
  assign sram_addr2 = sram_addr2_q;
  assign rsp_valid  = rsp_valid_q;

endmodule
